// File: rtl/demux_1_2.sv
// Registered 1-to-2 stream demultiplexer: each output port owns a 2-entry FIFO.
// Optional per-port delivered-beat counters are enabled with `define DEMUX_1_2_CNT_EN.
module demux_1_2 #(
    parameter int WIDTH = 8
`ifdef DEMUX_1_2_CNT_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_i,
    input  logic             sel_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] a_o,
    output logic             a_valid_o,
    input  logic             a_ready_i,
    output logic [WIDTH-1:0] b_o,
    output logic             b_valid_o,
    input  logic             b_ready_i
`ifdef DEMUX_1_2_CNT_EN
    ,
    output logic [CNT_W-1:0] a_cnt_o,
    output logic [CNT_W-1:0] b_cnt_o
`endif
);

    logic [1:0]            out_ready;
    logic [1:0]            full_vec;
    logic [1:0]            valid_vec;
    logic [1:0][WIDTH-1:0] head_vec;
`ifdef DEMUX_1_2_CNT_EN
    logic [1:0][CNT_W-1:0] beat_cnt_vec;
`endif

    assign out_ready = {b_ready_i, a_ready_i};

    // Acceptance looks only at the selected port's fill level, never at the consumer readies.
    assign ready_o = !reset && !(sel_i ? full_vec[1] : full_vec[0]);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            logic [WIDTH-1:0] mem_reg [2];
            logic             rd_ptr_reg;
            logic             wr_ptr_reg;
            logic [1:0]       cnt_reg;
            logic [WIDTH-1:0] head_reg;

            logic             push;
            logic             pop;
            logic [1:0]       cnt_after_pop;
            logic [1:0]       cnt_next;
            logic             rd_ptr_next;
            logic             wr_ptr_next;
            logic [WIDTH-1:0] head_next;

            always_comb begin
                push          = valid_i && ready_o && (sel_i == 1'(gi));
                pop           = (cnt_reg != 2'd0) && out_ready[gi];
                cnt_after_pop = cnt_reg - {1'b0, pop};
                cnt_next      = cnt_after_pop + {1'b0, push};
                rd_ptr_next   = rd_ptr_reg ^ pop;
                wr_ptr_next   = wr_ptr_reg ^ push;
                head_next     = head_reg;
                // An empty port keeps showing its last head; a beat landing in an
                // otherwise empty FIFO bypasses storage to become the head directly.
                if (cnt_next != 2'd0) begin
                    if (cnt_after_pop == 2'd0) begin
                        head_next = data_i;
                    end else begin
                        head_next = mem_reg[rd_ptr_next];
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_reg    <= 2'd0;
                    rd_ptr_reg <= 1'b0;
                    wr_ptr_reg <= 1'b0;
                    head_reg   <= '0;
                end else begin
                    cnt_reg    <= cnt_next;
                    rd_ptr_reg <= rd_ptr_next;
                    wr_ptr_reg <= wr_ptr_next;
                    head_reg   <= head_next;
                end
            end

            always_ff @(posedge clk) begin
                if (push) begin
                    mem_reg[wr_ptr_reg] <= data_i;
                end
            end

`ifdef DEMUX_1_2_CNT_EN
            logic [CNT_W-1:0] beat_cnt_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    beat_cnt_reg <= '0;
                end else if (pop) begin
                    beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
                end
            end

            assign beat_cnt_vec[gi] = beat_cnt_reg;
`endif

            assign full_vec[gi]  = (cnt_reg == 2'd2);
            assign valid_vec[gi] = (cnt_reg != 2'd0);
            assign head_vec[gi]  = head_reg;
        end
    endgenerate

    assign a_o       = head_vec[0];
    assign b_o       = head_vec[1];
    assign a_valid_o = valid_vec[0];
    assign b_valid_o = valid_vec[1];
`ifdef DEMUX_1_2_CNT_EN
    assign a_cnt_o   = beat_cnt_vec[0];
    assign b_cnt_o   = beat_cnt_vec[1];
`endif

endmodule

// File: doc/demux_1_2.md
# demux_1_2

- Registered 1-to-2 stream demultiplexer, the complement of the 2:1 mux.
- Accepts one WIDTH-bit beat per cycle on a valid/ready input.
- `sel_i`, sampled with the beat, routes it to output port A (`sel_i=0`) or port B (`sel_i=1`).
- Each output port has its own 2-entry FIFO, so a stalled port does not corrupt the other port's traffic.
- Sits between a single producer and two independent consumers.

## Interface

Parameters:

- `WIDTH`, default 8: data width of input and both outputs.
- `CNT_W`, default 16: width of the beat counters (only when `DEMUX_1_2_CNT_EN` is defined).

Ports (clock and reset first):

- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `data_i` input WIDTH: input beat.
- `sel_i` input 1: destination, 0 = A, 1 = B; qualified by `valid_i`.
- `valid_i` input 1: input beat valid.
- `ready_o` output 1: block can accept the current beat.
- `a_o` output WIDTH: port A data.
- `a_valid_o` output 1: port A beat valid.
- `a_ready_i` input 1: port A consumer ready.
- `b_o` output WIDTH: port B data.
- `b_valid_o` output 1: port B beat valid.
- `b_ready_i` input 1: port B consumer ready.
- `a_cnt_o` output CNT_W: beats delivered on A (only with `DEMUX_1_2_CNT_EN`).
- `b_cnt_o` output CNT_W: beats delivered on B (only with `DEMUX_1_2_CNT_EN`).

## Operation

- Each port has a 2-entry FIFO: storage, read pointer, write pointer and a 2-bit count (0..2).
- `ready_o` = `!reset && (sel_i ? cnt_b != 2 : cnt_a != 2)`.
  - It depends combinationally on `sel_i` and `reset` only.
  - There is no path from `a_ready_i` or `b_ready_i` to `ready_o`.
- Input transfer occurs when `valid_i && ready_o`; the beat is written into the selected port's FIFO.
- Output transfer on A occurs when `a_valid_o && a_ready_i` and pops the head; B behaves identically.
- Push and pop on the same port in the same cycle leave the count unchanged. This is legal only when count is 1, or count is 2 with push blocked.
- `a_valid_o` = (`cnt_a != 0`); `a_o` = head entry. B is identical.
- The head is held stable while valid is high and ready is low.
- When a port is empty, its data output holds the last head value (0 after reset).
- Per-port ordering is preserved. There is no ordering relation between A and B.
- The non-selected port is unaffected by an input beat.
- Port behaviour by count:
  - count 0, push: count becomes 1.
  - count 1, push and pop: count stays 1, new head next cycle.
  - count 2: `ready_o` is low for beats selecting that port; beats selecting the other port are still accepted.
- `valid_i` low: `sel_i` and `data_i` are don't-care, nothing is written.

## Timing

- Latency: a beat accepted at edge N is visible on its port (`x_valid_o` high) after edge N, i.e. 1 cycle.
- Throughput: 1 beat/cycle into each port while its consumer holds ready high. With continuous ready the count never exceeds 1.
- Reset: on an edge with `reset` high, both counts, pointers and data outputs go to 0.
  - `a_valid_o` = `b_valid_o` = 0; counters = 0.
  - `ready_o` = 0 while `reset` is high.
  - Reset mid-stream discards all buffered beats; no beat is delivered after reset that was accepted before it.
- First input acceptance is possible in the first cycle with `reset` low.

## Configuration

- `DEMUX_1_2_CNT_EN` defined:
  - `a_cnt_o` and `b_cnt_o` exist; each increments by 1 on every output transfer of its port.
  - They wrap from 2^CNT_W−1 to 0 and are reset to 0.
- Undefined: the ports and counter logic are absent. All other behaviour is identical.

## Test plan

- **Routing.** After reset, send 8'hA5 with `sel_i=0`, then 8'h3C with `sel_i=1`, both readies high.
  - A delivers A5 one cycle after acceptance and B delivers 3C one cycle after acceptance.
  - Neither port ever shows the other's beat.
- **Backpressure/full.** Hold `a_ready_i=0` and push 8'h01, 8'h02, 8'h03 to A.
  - The first two are accepted, then `ready_o=0` while `sel_i=0`.
  - A beat with `sel_i=1` is still accepted and delivered on B.
  - Raise `a_ready_i`: A delivers 01, 02, 03 in order, one per cycle, with 03 accepted once space frees.
- **Stable hold.** With `a_valid_o=1` and `a_ready_i=0` for 5 cycles, `a_o` stays constant; `a_o` changes only after a transfer.
- **Throughput.** Both readies high; 16 random beats with `sel_i` = `$random%2` on consecutive cycles.
  - `ready_o` stays 1 throughout.
  - Each port's output sequence equals the input subsequence for that port.
- **Reset mid-operation.** Fill A with 2 beats, assert `reset` for 1 cycle.
  - Next cycle `a_valid_o=0`, `a_o=0`, `ready_o` returns to 1.
  - The discarded beats never appear.
- **Counters** (`DEMUX_1_2_CNT_EN`). With CNT_W=4, deliver 17 beats on A and 3 on B; expect `a_cnt_o=1` (wrapped) and `b_cnt_o=3`.
